// File: rtl/pulsesync_pkg.sv
// Shared definitions for the pulse pacer and the toggle pulse synchronizer benches.
package pulsesync_pkg;

  // Pacer FSM encodings
  typedef enum logic {
    PACER_IDLE = 1'b0,
    PACER_HOLD = 1'b1
  } pacer_state_e;

  // Default pacer parameters
  localparam int unsigned PACER_GAP_DEF   = 6;
  localparam int unsigned PACER_CNT_W_DEF = 4;

endpackage : pulsesync_pkg

// File: rtl/pulse_pacer.sv
// Queues dense event pulses and re-emits them spaced GAP cycles apart for a toggle synchronizer.
module pulse_pacer
  import pulsesync_pkg::*;
#(
  parameter int unsigned GAP   = PACER_GAP_DEF,
  parameter int unsigned CNT_W = PACER_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned      GAP_W      = $clog2(GAP);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 2);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  pacer_state_e     state_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             pulse_out_q;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             overflow_q;

  logic emit_c;
  logic accept_c;
  logic drop_c;

  // Emit decision and queue admission
  always_comb begin
    emit_c   = 1'b0;
    accept_c = 1'b0;
    drop_c   = 1'b0;
    emit_c   = (state_q == PACER_IDLE) && ((pending_q != '0) || pulse_in);
    accept_c = (pending_q != CNT_MAX) || emit_c;
    drop_c   = pulse_in && !accept_c;
  end

  // Pacing FSM: one pulse out, then hold for the remaining GAP-1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PACER_IDLE;
      gap_cnt_q   <= '0;
      pulse_out_q <= 1'b0;
    end else begin
      case (state_q)
        PACER_IDLE: begin
          if (emit_c) begin
            pulse_out_q <= 1'b1;
            gap_cnt_q   <= GAP_RELOAD;
            state_q     <= PACER_HOLD;
          end else begin
            pulse_out_q <= 1'b0;
          end
        end
        PACER_HOLD: begin
          pulse_out_q <= 1'b0;
          if (gap_cnt_q == '0) begin
            state_q <= PACER_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          pulse_out_q <= 1'b0;
          state_q     <= PACER_IDLE;
        end
      endcase
    end
  end

  // Saturating pending count: an accepted arrival and an emit in the same cycle cancel
  always_comb begin
    pending_d = pending_q;
    pending_d = pending_q + CNT_W'(pulse_in && accept_c) - CNT_W'(emit_c);
  end

  // Pending counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign pulse_out = pulse_out_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != PACER_IDLE) || (pending_q != '0);

endmodule : pulse_pacer

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer with GAP=4, CNT_W=2 (queue max 3).
module tb_pulse_pacer;

  logic       clk;
  logic       rst_n;
  logic       pulse_in;
  logic       clr_ovf;
  logic       pulse_out;
  logic [1:0] pending;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  pulse_pacer #(.GAP(4), .CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .clr_ovf  (clr_ovf),
    .pulse_out(pulse_out),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse_in = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse_out got %b expected 0", pulse_out); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d expected 0", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    #4 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      checks++; if (pulse_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got pulse_out=%b busy=%b expected 0 0", pulse_out, busy); end
    end
  endtask

  task automatic test_single();
    logic       e_po   [0:20];
    logic       e_busy [0:20];
    e_po   = '{0,1,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0};
    e_busy = '{0,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0};
    for (int r = 0; r < 20; r++) begin
      pulse_in = (r == 0);
      tick();
      checks++; if (pulse_out !== e_po[r+1]) begin errors++; $display("FAIL single_pulse_out a=%0d got %b expected %b", r+1, pulse_out, e_po[r+1]); end
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL single_pending a=%0d got %0d expected 0", r+1, pending); end
      checks++; if (busy !== e_busy[r+1]) begin errors++; $display("FAIL single_busy a=%0d got %b expected %b", r+1, busy, e_busy[r+1]); end
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       e_po   [0:20];
    logic [1:0] e_pend [0:20];
    logic       e_busy [0:20];
    e_po   = '{0,1,0,0,0, 1,0,0,0,1, 0,0,0,0,0, 0,0,0,0,0, 0};
    e_pend = '{0,0,1,2,2, 1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0, 0};
    e_busy = '{0,1,1,1,1, 1,1,1,1,1, 1,1,0,0,0, 0,0,0,0,0, 0};
    for (int r = 0; r < 20; r++) begin
      pulse_in = (r < 3);
      tick();
      checks++; if (pulse_out !== e_po[r+1]) begin errors++; $display("FAIL b2b_pulse_out a=%0d got %b expected %b", r+1, pulse_out, e_po[r+1]); end
      checks++; if (pending !== e_pend[r+1]) begin errors++; $display("FAIL b2b_pending a=%0d got %0d expected %0d", r+1, pending, e_pend[r+1]); end
      checks++; if (busy !== e_busy[r+1]) begin errors++; $display("FAIL b2b_busy a=%0d got %b expected %b", r+1, busy, e_busy[r+1]); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow a=%0d got %b expected 0", r+1, overflow); end
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_saturate();
    logic       e_po   [0:20];
    logic [1:0] e_pend [0:20];
    logic       e_ovf  [0:20];
    logic       e_busy [0:20];
    e_po   = '{0,1,0,0,0, 1,0,0,0,1, 0,0,0,1,0, 0,0,1,0,0, 0};
    e_pend = '{0,0,1,2,3, 3,3,3,3,2, 2,2,2,1,1, 1,1,0,0,0, 0};
    e_ovf  = '{0,0,0,0,0, 0,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1, 1};
    e_busy = '{0,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1, 0};
    for (int r = 0; r < 20; r++) begin
      pulse_in = (r < 6);
      tick();
      checks++; if (pulse_out !== e_po[r+1]) begin errors++; $display("FAIL sat_pulse_out a=%0d got %b expected %b", r+1, pulse_out, e_po[r+1]); end
      checks++; if (pending !== e_pend[r+1]) begin errors++; $display("FAIL sat_pending a=%0d got %0d expected %0d", r+1, pending, e_pend[r+1]); end
      checks++; if (overflow !== e_ovf[r+1]) begin errors++; $display("FAIL sat_overflow a=%0d got %b expected %b", r+1, overflow, e_ovf[r+1]); end
      checks++; if (busy !== e_busy[r+1]) begin errors++; $display("FAIL sat_busy a=%0d got %b expected %b", r+1, busy, e_busy[r+1]); end
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_clr_ovf();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_plain got %b expected 0", overflow); end
    for (int r = 0; r < 6; r++) begin
      pulse_in = 1'b1;
      clr_ovf  = (r == 5);
      tick();
      if (r == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_before_drop got %b expected 0", overflow); end
      end
    end
    pulse_in = 1'b0; clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop got %b expected 1", overflow); end
    repeat (20) tick();
    checks++; if (busy !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL clr_drain got busy=%b pending=%0d expected 0 0", busy, pending); end
  endtask

  task automatic test_async_reset();
    for (int r = 0; r < 3; r++) begin
      pulse_in = 1'b1;
      tick();
    end
    pulse_in = 1'b0;
    checks++; if (pending !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL arst_setup got pending=%0d busy=%b expected 2 1", pending, busy); end
    #4 rst_n = 1'b0;
    #1;
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL arst_pending got %0d expected 0", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got %b expected 0", overflow); end
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL arst_pulse_out got %b expected 0", pulse_out); end
    #9 rst_n = 1'b1;
    for (int r = 0; r < 12; r++) begin
      tick();
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL arst_no_pulse a=%0d got %b expected 0", r+1, pulse_out); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle got %b expected 0", busy); end
  endtask

  task automatic test_stream();
    int emitted = 0;
    int last_a  = -1;
    logic prev  = 1'b0;
    for (int r = 0; r < 114; r++) begin
      pulse_in = (r < 100);
      tick();
      if (pulse_out === 1'b1) begin
        emitted++;
        if (last_a >= 0) begin
          checks++; if (r + 1 - last_a != 4) begin errors++; $display("FAIL stream_gap a=%0d got %0d expected 4", r+1, r+1-last_a); end
        end
        last_a = r + 1;
      end
      checks++; if (prev === 1'b1 && pulse_out === 1'b1) begin errors++; $display("FAIL stream_consecutive a=%0d got 1 expected 0", r+1); end
      prev = pulse_out;
      if (r == 99) begin
        checks++; if (emitted != 25) begin errors++; $display("FAIL stream_emitted got %0d expected 25", emitted); end
        checks++; if (pending !== 2'd3) begin errors++; $display("FAIL stream_pending got %0d expected 3", pending); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stream_overflow got %b expected 1", overflow); end
      end
    end
    pulse_in = 1'b0;
    checks++; if (emitted != 28) begin errors++; $display("FAIL stream_total got %0d expected 28", emitted); end
    checks++; if (busy !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL stream_drain got busy=%b pending=%0d expected 0 0", busy, pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_clr_ovf();
    test_async_reset();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pulse_pacer
